// File: rtl/adder_share_arbiter_pkg.sv
// Shared width constants and requester-id type for the shared-adder arbiter.
package adder_share_arbiter_pkg;
    localparam int A_W   = 54;
    localparam int B_W   = 9;
    localparam int SUM_W = 55;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;
endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester, response and grant-counter bundle for adder_share_arbiter.
interface adder_share_arbiter_if
    import adder_share_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [A_W-1:0]   req0_a;
    logic [B_W-1:0]   req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [A_W-1:0]   req1_a;
    logic [B_W-1:0]   req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    req_id_t          rsp_id;
    logic [SUM_W-1:0] rsp_sum;

    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    // Requesters and consumer side
    modport master (
        output req0_valid, req0_a, req0_b, input req0_ready,
        output req1_valid, req1_a, req1_b, input req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, output rsp_ready,
        input  gnt_cnt0, gnt_cnt1
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, output req0_ready,
        input  req1_valid, req1_a, req1_b, output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, input rsp_ready,
        output gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/adder_share_arbiter_adder.sv
// customAdder54_45: unsigned 54-bit + 9-bit adder, full 55-bit result.
module customAdder54_45
    import adder_share_arbiter_pkg::*;
(
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [SUM_W-1:0] sum
);
    assign sum = {1'b0, a} + {{(SUM_W-B_W){1'b0}}, b};
endmodule

// File: rtl/adder_share_arbiter.sv
// Two requesters time-share one adder; round-robin grant, 1-cycle result register.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             free;
    logic             any_valid;
    logic             accept;
    req_id_t          sel;
    req_id_t          rr;
    logic [A_W-1:0]   mux_a;
    logic [B_W-1:0]   mux_b;
    logic [SUM_W-1:0] sum_d;

    logic             rsp_valid_q;
    req_id_t          rsp_id_q;
    logic [SUM_W-1:0] rsp_sum_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Arbitration: lone requester wins outright, contention resolved by rr.
    // rst_n gates accept so readies stay low while reset is held.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) sel = rr;
        else if (bus.req1_valid)              sel = REQ1;
        else                                  sel = REQ0;
        free   = !rsp_valid_q || bus.rsp_ready;
        accept = rst_n && free && any_valid;
        mux_a  = (sel == REQ1) ? bus.req1_a : bus.req0_a;
        mux_b  = (sel == REQ1) ? bus.req1_b : bus.req0_b;
    end

    customAdder54_45 u_adder (
        .a   (mux_a),
        .b   (mux_b),
        .sum (sum_d)
    );

    // Result register: load on grant (also covers drain+accept), clear on bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ0;
            rsp_sum_q   <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= sel;
            rsp_sum_q   <= sum_d;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer moves only on a grant, pointing away from the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr <= REQ0;
        else if (accept) rr <= ~sel;
    end

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (sel == REQ0 && cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_ONE;
            if (sel == REQ1 && cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + CNT_ONE;
        end
    end

    assign bus.req0_ready = accept && (sel == REQ0);
    assign bus.req1_ready = accept && (sel == REQ1);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.gnt_cnt0   = cnt0_q;
    assign bus.gnt_cnt1   = cnt1_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a negedge scoreboard model.
module tb_adder_share_arbiter;
    import adder_share_arbiter_pkg::*;

    localparam int CW = 4;

    typedef struct {
        logic        id;
        logic [54:0] sum;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    exp_t        sb[$];
    logic        m_rr;
    logic [CW-1:0] m_cnt0, m_cnt1;
    logic        m_free, m_sel, m_acc;
    exp_t        e;

    logic        exp_id;
    logic [54:0] held;
    logic [54:0] big;

    adder_share_arbiter_if #(.CNT_W(CW)) bus ();

    adder_share_arbiter #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [54:0] ref_sum(input logic [53:0] a, input logic [8:0] b);
        return {1'b0, a} + {46'b0, b};
    endfunction

    // Reference model: checks current outputs, predicts handshakes for the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_rr   = 1'b0;
            m_cnt0 = '0;
            m_cnt1 = '0;
            chk("rst_valid",  bus.rsp_valid,  0);
            chk("rst_id",     bus.rsp_id,     0);
            chk("rst_sum",    bus.rsp_sum,    0);
            chk("rst_ready0", bus.req0_ready, 0);
            chk("rst_ready1", bus.req1_ready, 0);
            chk("rst_cnt0",   bus.gnt_cnt0,   0);
            chk("rst_cnt1",   bus.gnt_cnt1,   0);
        end else begin
            chk("valid", bus.rsp_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                chk("id",  bus.rsp_id,  sb[0].id);
                chk("sum", bus.rsp_sum, sb[0].sum);
            end
            chk("cnt0", bus.gnt_cnt0, m_cnt0);
            chk("cnt1", bus.gnt_cnt1, m_cnt1);
            m_free = (sb.size() == 0) || bus.rsp_ready;
            m_sel  = (bus.req0_valid && bus.req1_valid) ? m_rr : bus.req1_valid;
            m_acc  = m_free && (bus.req0_valid || bus.req1_valid);
            chk("ready0", bus.req0_ready, m_acc && !m_sel);
            chk("ready1", bus.req1_ready, m_acc && m_sel);
            if (sb.size() != 0 && bus.rsp_ready) void'(sb.pop_front());
            if (m_acc) begin
                e.id  = m_sel;
                e.sum = m_sel ? ref_sum(bus.req1_a, bus.req1_b) : ref_sum(bus.req0_a, bus.req0_b);
                sb.push_back(e);
                m_rr = !m_sel;
                if (m_sel) begin
                    if (m_cnt1 != '1) m_cnt1 = m_cnt1 + 1'b1;
                end else begin
                    if (m_cnt0 != '1) m_cnt0 = m_cnt0 + 1'b1;
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        repeat (2) cyc();
        chk("init_valid", bus.rsp_valid, 0);
        rst_n = 1'b1;

        // Single requester
        bus.req0_a = 54'd100; bus.req0_b = 9'd5; bus.req0_valid = 1'b1;
        cyc();
        bus.req0_valid = 1'b0;
        chk("single_valid", bus.rsp_valid, 1);
        chk("single_id",    bus.rsp_id,    0);
        chk("single_sum",   bus.rsp_sum,   105);
        chk("single_cnt0",  bus.gnt_cnt0,  1);
        cyc();
        chk("drain_clear", bus.rsp_valid, 0);

        // Both valid: rr points at 1 after the grant to 0
        bus.req0_a = 54'd1000; bus.req0_b = 9'd1;
        bus.req1_a = 54'd2000; bus.req1_b = 9'd2;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        exp_id = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("alt_valid", bus.rsp_valid, 1);
            chk("alt_id",    bus.rsp_id,    exp_id);
            exp_id = ~exp_id;
            bus.req0_a = bus.req0_a + 54'd7;
            bus.req1_b = bus.req1_b + 9'd3;
        end
        chk("alt_cnt0", bus.gnt_cnt0, 4);
        chk("alt_cnt1", bus.gnt_cnt1, 3);

        // Backpressure: hold 5 cycles, then drain+accept in one cycle
        bus.rsp_ready = 1'b0;
        held = sb[0].sum;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            chk("bp_hold",   bus.rsp_sum,    held);
        end
        bus.rsp_ready = 1'b1;
        cyc();
        chk("bp_resume_valid", bus.rsp_valid, 1);
        chk("bp_resume_id",    bus.rsp_id,    exp_id);
        chk("bp_resume_cnt1",  bus.gnt_cnt1,  4);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        cyc();
        chk("bp_drained", bus.rsp_valid, 0);

        // Carry out of bit 53
        bus.req1_a = '1; bus.req1_b = 9'd1; bus.req1_valid = 1'b1;
        cyc();
        big = 55'd1 << 54;
        chk("carry_sum", bus.rsp_sum, big);
        bus.req1_b = 9'd511;
        cyc();
        bus.req1_valid = 1'b0;
        chk("max_sum", bus.rsp_sum, big + 55'd510);

        // Reset while a result is held
        bus.rsp_ready = 1'b0;
        bus.req0_a = 54'd7; bus.req0_b = 9'd3; bus.req0_valid = 1'b1;
        cyc();
        bus.req0_valid = 1'b0;
        chk("pre_rst_valid", bus.rsp_valid, 1);
        #1 rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("mid_rst_valid",  bus.rsp_valid,  0);
        chk("mid_rst_cnt0",   bus.gnt_cnt0,   0);
        chk("mid_rst_cnt1",   bus.gnt_cnt1,   0);
        chk("mid_rst_ready0", bus.req0_ready, 0);
        chk("mid_rst_ready1", bus.req1_ready, 0);
        repeat (2) cyc();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_idle", bus.rsp_valid, 0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        cyc();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("post_rst_first_id", bus.rsp_id, 0);
        chk("post_rst_sum",      bus.rsp_sum, ref_sum(54'd7, 9'd3));

        // Counter saturation on requester 1
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.req1_a = 54'(i * 3);
            cyc();
        end
        bus.req1_valid = 1'b0;
        cyc();
        chk("sat_cnt1", bus.gnt_cnt1, 15);
        chk("sat_cnt0", bus.gnt_cnt0, 1);

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of the per-requester grant counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 pair accepted this cycle when valid&ready.
REQ-006 req0_a  input  54  requester 0 wide operand, unsigned.
REQ-007 req0_b  input  9  requester 0 narrow operand, unsigned.
REQ-008 req1_valid, req1_ready, req1_a[53:0], req1_b[8:0]: same as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result register holds a valid sum.
REQ-010 rsp_ready  input  1  consumer takes the result when rsp_valid&rsp_ready.
REQ-011 rsp_id  output  1  requester index that produced rsp_sum.
REQ-012 rsp_sum  output  55  registered sum a + zero-extended b, carry in bit 54.
REQ-013 gnt_cnt0, gnt_cnt1  output  CNT_W each  number of grants issued per requester.

Function
REQ-014 The block SHALL time-share one 54+9-bit adder between two requesters; exactly one grant per cycle at most.
REQ-015 Output-stage free condition: free = !rsp_valid | rsp_ready.
REQ-016 Grant only when free; reqN_ready = free & grant_to_N; ready SHALL be 0 for a non-granted requester.
REQ-017 Arbitration: round-robin via 1-bit pointer rr; if only one valid, grant it regardless of rr; if both valid, grant requester rr.
REQ-018 On each accepted grant to requester N, rr SHALL become !N; rr SHALL not change without a grant.
REQ-019 Latency: a pair accepted at edge k SHALL appear on rsp_sum/rsp_id with rsp_valid=1 after edge k (1-cycle latency).
REQ-020 rsp_sum = {1'b0,a} + {46'b0,b}; full 55-bit result, no truncation or saturation; a=2^54-1, b=511 gives 2^54+510.
REQ-021 Result register SHALL hold rsp_sum/rsp_id stable while rsp_valid & !rsp_ready.
REQ-022 Simultaneous drain and accept (rsp_valid & rsp_ready & grant): new result loaded, rsp_valid stays 1, full throughput of one result per cycle.
REQ-023 Drain without grant: rsp_valid clears next cycle.
REQ-024 Valid signals SHALL not depend on ready; ready SHALL depend on valid only through arbitration (no combinational loop from rsp_ready to reqN_valid).
REQ-025 gnt_cntN increments by 1 per accepted grant to N, saturates at 2^CNT_W-1 (no wrap).

Reset
REQ-026 While rst_n=0: rsp_valid=0, rsp_id=0, rsp_sum=0, rr=0, gnt_cnt0=gnt_cnt1=0, req0_ready=req1_ready=0.
REQ-027 Reset asserted mid-transfer SHALL discard the held result; no result emitted after release until a new grant.
REQ-028 First grant after reset with both valid SHALL go to requester 0.

Structure
REQ-029 Shared package holds width constants: A_W=54, B_W=9, SUM_W=55, and the requester-id type.
REQ-030 The adder SHALL be the existing customAdder54_45 sub-module, instantiated once, fed by the arbitration mux; no second adder.
REQ-031 Arbiter (rr pointer, grant logic) and result register in this module; no further sub-modules.

Verification
REQ-032 Single requester: req0 a=100, b=5 valid, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=105, gnt_cnt0=1.
REQ-033 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one result per cycle; rsp_id alternates.
REQ-034 Backpressure: rsp_ready=0 with result held -> both readies 0, rsp_sum stable 5 cycles; rsp_ready=1 -> drain and new accept same cycle.
REQ-035 Carry: a=2^54-1, b=1 -> rsp_sum=2^54 (bit 54 set, bits 53:0 zero).
REQ-036 Reset mid-operation: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately, counters 0, rr=0; first post-reset both-valid grant to requester 0.
REQ-037 Counter saturation with CNT_W=4: 20 grants to requester 1 -> gnt_cnt1=15, gnt_cnt0 unaffected.
